// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, DataMem strobe levels,
// FSM states and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] MEM_ON  = 2'd1;
  localparam logic [1:0] MEM_OFF = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // The reserved size is treated as a misaligned access so it takes the error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: merges store data into a memory word and
// extracts/extends a load lane. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_word >> {addr_lo, 3'b000};
    ld_data = mem_word;
    case (size)
      SZ_BYTE: ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: ld_data = mem_word;
    endcase
  end

  always_comb begin
    merged = mem_word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = st_data[7:0];
      SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      default: merged = st_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a one-cycle-latency DataMem.
// Sub-word stores are done as read-modify-write of the containing word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; latches it on acceptance
// ST_RD    | mem_read asserted, address presented
// ST_RWAIT | mem_read held; mem_rdata sampled at the end of this cycle
// ST_WR    | one-cycle mem_write of the full (possibly merged) word
// ST_RESP  | one-cycle resp_valid pulse, then back to idle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_write,
  output logic [1:0]        mem_read,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0]       merged_word;
  logic [31:0]       load_word;

  mem_lane_align u_lane_align (
    .mem_word (mem_rdata),
    .st_data  (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .merged   (merged_word),
    .ld_data  (load_word)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = is_misaligned(req_size, req_addr[1:0]);
          if (err_d) begin
            state_d = ST_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            // Full-word stores skip the read; the write word is known now.
            state_d     = ST_WR;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (write_q) begin
          state_d     = ST_WR;
          mem_wdata_d = merged_word;
        end else begin
          state_d = ST_RESP;
          rdata_d = load_word;
        end
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Strobes decode straight from the state flop so reset clears them at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) & err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = ((state_q == ST_RD) || (state_q == ST_RWAIT)) ? MEM_ON : MEM_OFF;
  assign mem_write  = (state_q == ST_WR) ? MEM_ON : MEM_OFF;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: DataMem model, response scoreboard
// with latency tracking, and one task per scenario.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_write;
  logic [1:0]  mem_read;
  logic [31:0] mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMem: read data appears one edge after mem_read, writes land on the edge.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_read == 2'd1) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_write == 2'd1) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          acc_n = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          resp_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input logic [7:0] lt);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.lat   = lt;
    return e;
  endfunction

  // Reference load: pick bytes out of the word, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
    logic [7:0]  b [4];
    logic [31:0] v;
    b[0] = w[7:0];
    b[1] = w[15:8];
    b[2] = w[23:16];
    b[3] = w[31:24];
    if (sz == SZ_BYTE) begin
      v = {24'h0, b[a]};
      if (sg && b[a][7]) v[31:8] = 24'hFFFFFF;
    end else if (sz == SZ_HALF) begin
      v = {16'h0, b[{a[1], 1'b1}], b[{a[1], 1'b0}]};
      if (sg && v[15]) v[31:16] = 16'hFFFF;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (mem_read != 2'd0 && mem_write != 2'd0) overlap_cnt++;
    if (mem_read == 2'd1) rd_cnt++;
    if (mem_write == 2'd1) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (resp_valid) begin
      resp_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_resp got rdata=%h err=%b expected no response", resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_rdata got %h expected %h", resp_rdata, e.rdata);
        end
        checks++;
        if (resp_err !== e.err) begin
          errors++;
          $display("FAIL sb_err got %b expected %b", resp_err, e.err);
        end
        checks++;
        if ((ncyc - acc_n) != int'(e.lat)) begin
          errors++;
          $display("FAIL sb_latency got %0d expected %0d", ncyc - acc_n, e.lat);
        end
      end
    end
    if (req_valid && req_ready && !rst) acc_n = ncyc;
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout req_ready=%b expected 1", req_ready);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b err=%b rd=%h mr=%0d mw=%0d ma=%h mwd=%h expected 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_store();
    int w0 = wr_cnt;
    sb.push_back(mk(32'h0, 1'b0, 8'd2));
    issue(1'b1, SZ_WORD, 1'b0, 32'd20, 32'h9999_9999);
    wait_drain();
    checks++;
    if (wr_cnt - w0 != 1) begin
      errors++; $display("FAIL wstore_write_cycles got %0d expected 1", wr_cnt - w0);
    end
    checks++;
    if (last_wr_addr !== 32'd20 || last_wr_data !== 32'h9999_9999) begin
      errors++; $display("FAIL wstore_write got addr=%h data=%h expected 00000014 99999999", last_wr_addr, last_wr_data);
    end
    checks++;
    if (mem_write !== 2'd0 || mem_read !== 2'd0 || mem_wdata !== 32'h9999_9999) begin
      errors++; $display("FAIL wstore_idle_hold got mw=%0d mr=%0d mwd=%h expected 0 0 99999999", mem_write, mem_read, mem_wdata);
    end
  endtask

  task automatic test_rmw_store();
    int w0;
    sb.push_back(mk(32'h0, 1'b0, 8'd2));
    issue(1'b1, SZ_WORD, 1'b0, 32'd40, 32'hEEEE_EEEE);
    wait_drain();
    w0 = wr_cnt;
    sb.push_back(mk(32'h0, 1'b0, 8'd4));
    issue(1'b1, SZ_BYTE, 1'b0, 32'd41, 32'h0000_005A);
    wait_drain();
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 32'd40 || last_wr_data !== 32'hEEEE_5AEE) begin
      errors++; $display("FAIL rmw_byte got n=%0d addr=%h data=%h expected 1 00000028 eeee5aee", wr_cnt - w0, last_wr_addr, last_wr_data);
    end
    sb.push_back(mk(32'h0, 1'b0, 8'd4));
    issue(1'b1, SZ_HALF, 1'b0, 32'd42, 32'h1234_BEEF);
    wait_drain();
    checks++;
    if (last_wr_data !== 32'hBEEF_5AEE) begin
      errors++; $display("FAIL rmw_half got %h expected beef5aee", last_wr_data);
    end
    sb.push_back(mk(32'hBEEF_5AEE, 1'b0, 8'd3));
    issue(1'b0, SZ_WORD, 1'b0, 32'd40, 32'h0);
    wait_drain();
  endtask

  task automatic test_loads();
    logic [31:0] w = 32'h8001_F07F;
    sb.push_back(mk(32'h0, 1'b0, 8'd2));
    issue(1'b1, SZ_WORD, 1'b0, 32'd20, w);
    wait_drain();
    sb.push_back(mk(32'h0000_007F, 1'b0, 8'd3)); issue(1'b0, SZ_BYTE, 1'b1, 32'd20, 32'h0); wait_drain();
    sb.push_back(mk(32'hFFFF_FFF0, 1'b0, 8'd3)); issue(1'b0, SZ_BYTE, 1'b1, 32'd21, 32'h0); wait_drain();
    sb.push_back(mk(32'h0000_8001, 1'b0, 8'd3)); issue(1'b0, SZ_HALF, 1'b0, 32'd22, 32'h0); wait_drain();
    sb.push_back(mk(32'hFFFF_8001, 1'b0, 8'd3)); issue(1'b0, SZ_HALF, 1'b1, 32'd22, 32'h0); wait_drain();
    for (int a = 0; a < 4; a++) begin
      for (int sg = 0; sg < 2; sg++) begin
        sb.push_back(mk(model_load(w, 2'(a), SZ_BYTE, 1'(sg)), 1'b0, 8'd3));
        issue(1'b0, SZ_BYTE, 1'(sg), 32'd20 + 32'(a), 32'h0);
        wait_drain();
      end
    end
    sb.push_back(mk(model_load(w, 2'd0, SZ_HALF, 1'b1), 1'b0, 8'd3));
    issue(1'b0, SZ_HALF, 1'b1, 32'd20, 32'h0);
    wait_drain();
    sb.push_back(mk(w, 1'b0, 8'd3));
    issue(1'b0, SZ_WORD, 1'b1, 32'd20, 32'h0);
    wait_drain();
  endtask

  task automatic test_misaligned();
    int r0 = rd_cnt;
    int w0 = wr_cnt;
    sb.push_back(mk(32'h0, 1'b1, 8'd1)); issue(1'b0, SZ_HALF, 1'b0, 32'd21, 32'h0); wait_drain();
    sb.push_back(mk(32'h0, 1'b1, 8'd1)); issue(1'b0, SZ_WORD, 1'b0, 32'd42, 32'h0); wait_drain();
    sb.push_back(mk(32'h0, 1'b1, 8'd1)); issue(1'b0, SZ_RSVD, 1'b0, 32'd20, 32'h0); wait_drain();
    sb.push_back(mk(32'h0, 1'b1, 8'd1)); issue(1'b1, SZ_HALF, 1'b0, 32'd23, 32'hFFFF); wait_drain();
    sb.push_back(mk(32'h0, 1'b1, 8'd1)); issue(1'b1, SZ_WORD, 1'b0, 32'd41, 32'h1); wait_drain();
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errors++; $display("FAIL misalign_mem_activity got reads=%0d writes=%0d expected 0 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    int rc0 = resp_cnt;
    issue(1'b1, SZ_BYTE, 1'b0, 32'd43, 32'h0000_0011);
    @(posedge clk); #1;
    checks++;
    if (mem_read !== 2'd1) begin
      errors++; $display("FAIL rst_mid_in_rwait got mem_read=%0d expected 1", mem_read);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_outputs got ready=%b rv=%b err=%b rd=%h mr=%0d mw=%0d ma=%h mwd=%h expected 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != w0 || resp_cnt != rc0) begin
      errors++; $display("FAIL rst_mid_abandon got writes=%0d resps=%0d expected 0 0", wr_cnt - w0, resp_cnt - rc0);
    end
    checks++;
    if (mem[10] !== 32'hBEEF_5AEE) begin
      errors++; $display("FAIL rst_mid_mem got %h expected beef5aee", mem[10]);
    end
  endtask

  task automatic test_back_to_back();
    int  rv = -1;
    int  a2 = -1;
    bit  ready_bad = 1'b0;
    bit  got1 = 1'b0;
    sb.push_back(mk(32'hBEEF_5AEE, 1'b0, 8'd3));
    sb.push_back(mk(32'hFFFF_FFF0, 1'b0, 8'd3));
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'd40; req_wdata = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got1 = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_size = SZ_BYTE; req_signed = 1'b1; req_addr = 32'd21;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid && rv < 0) rv = i;
      if (rv < 0 && req_ready) ready_bad = 1'b1;
      if (req_valid && req_ready) begin
        a2 = i;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (!got1 || ready_bad) begin
      errors++; $display("FAIL b2b_ready_low got first_accepted=%b ready_seen=%b expected 1 0", got1, ready_bad);
    end
    checks++;
    if (rv < 0 || a2 != rv + 1) begin
      errors++; $display("FAIL b2b_gap got resp_at=%0d accept_at=%0d expected accept one cycle after resp", rv, a2);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_rmw_store();
    test_loads();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (overlap_cnt != 0) begin
      errors++; $display("FAIL rw_overlap got %0d cycles expected 0", overlap_cnt);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
